// File: rtl/cam_pwr_seq_pkg.sv
// Shared state encodings and per-state sensor pin values for the camera power sequencer.
package cam_seq_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PWDN_HOLD = 3'd1;
    localparam logic [2:0] ST_CLK_ON    = 3'd2;
    localparam logic [2:0] ST_RST_REL   = 3'd3;
    localparam logic [2:0] ST_READY     = 3'd4;

    typedef struct packed {
        logic pwdn;
        logic rst_n;
        logic xclk_en;
        logic busy;
        logic ready;
    } pins_t;

    // Bit order: pwdn, rst_n, xclk_en, busy, ready
    localparam pins_t PINS_IDLE      = 5'b1_0_0_0_0;
    localparam pins_t PINS_PWDN_HOLD = 5'b1_0_0_1_0;
    localparam pins_t PINS_CLK_ON    = 5'b0_0_1_1_0;
    localparam pins_t PINS_RST_REL   = 5'b0_1_1_1_0;
    localparam pins_t PINS_READY     = 5'b0_1_1_0_1;

    function automatic pins_t pins_of(input logic [2:0] st);
        case (st)
            ST_PWDN_HOLD: pins_of = PINS_PWDN_HOLD;
            ST_CLK_ON:    pins_of = PINS_CLK_ON;
            ST_RST_REL:   pins_of = PINS_RST_REL;
            ST_READY:     pins_of = PINS_READY;
            default:      pins_of = PINS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cam_pwr_seq_if.sv
// Control and sensor-pin bundle between the power sequencer and its controller.
interface cam_pwr_seq_if;

    logic start;
    logic abort;
    logic cam_pwdn;
    logic cam_rst_n;
    logic xclk_en;
    logic busy;
    logic ready;
    logic tick_us;

    modport master (
        output start, abort,
        input  cam_pwdn, cam_rst_n, xclk_en, busy, ready, tick_us
    );

    modport slave (
        input  start, abort,
        output cam_pwdn, cam_rst_n, xclk_en, busy, ready, tick_us
    );

endinterface

// File: rtl/cam_pwr_seq_us_tick_gen.sv
// 1 us tick prescaler with synchronous clear; tick is high while the count sits at TICK_DIV-1.
module us_tick_gen #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

    logic [7:0] count;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || !en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera sensor power-up sequencer: power-down hold, clock-on with reset, reset release, ready.
module cam_pwr_seq
    import cam_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned T_PWDN_US   = 1000,
    parameter int unsigned T_RST_US    = 1000,
    parameter int unsigned T_SETTLE_US = 5000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk_in,
    input  logic           reset,
    cam_pwr_seq_if.slave   bus
);

    if (TICK_DIV < 2 || TICK_DIV > 255) begin : g_bad_tick_div
        $fatal(1, "cam_pwr_seq: TICK_DIV out of range 2..255");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $fatal(1, "cam_pwr_seq: CNT_W out of range 1..32");
    end
    if (T_PWDN_US < 1 || 64'(T_PWDN_US) >= (64'd1 << CNT_W)) begin : g_bad_t_pwdn
        $fatal(1, "cam_pwr_seq: T_PWDN_US does not fit the delay counter");
    end
    if (T_RST_US < 1 || 64'(T_RST_US) >= (64'd1 << CNT_W)) begin : g_bad_t_rst
        $fatal(1, "cam_pwr_seq: T_RST_US does not fit the delay counter");
    end
    if (T_SETTLE_US < 1 || 64'(T_SETTLE_US) >= (64'd1 << CNT_W)) begin : g_bad_t_settle
        $fatal(1, "cam_pwr_seq: T_SETTLE_US does not fit the delay counter");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] dly_load;
    logic             timed;
    logic             entry;
    logic             tick;
    pins_t            pins;

    assign timed = (state == ST_PWDN_HOLD) || (state == ST_CLK_ON) || (state == ST_RST_REL);
    assign entry = (state_nxt != state);

    // Clearing on entry makes the first tick of every state land exactly TICK_DIV cycles in.
    us_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (entry),
        .en     (timed),
        .tick   (tick)
    );

    always_comb begin
        state_nxt = state;
        if (bus.abort && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_READY: if (bus.start) state_nxt = ST_PWDN_HOLD;
                ST_PWDN_HOLD:      if (tick && dly_cnt == '0) state_nxt = ST_CLK_ON;
                ST_CLK_ON:         if (tick && dly_cnt == '0) state_nxt = ST_RST_REL;
                ST_RST_REL:        if (tick && dly_cnt == '0) state_nxt = ST_READY;
                default:           state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state_nxt)
            ST_PWDN_HOLD: dly_load = CNT_W'(T_PWDN_US - 1);
            ST_CLK_ON:    dly_load = CNT_W'(T_RST_US - 1);
            ST_RST_REL:   dly_load = CNT_W'(T_SETTLE_US - 1);
            default:      dly_load = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            dly_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (entry) begin
                dly_cnt <= dly_load;
            end else if (tick && dly_cnt != '0) begin
                dly_cnt <= dly_cnt - 1'b1;
            end
        end
    end

    assign pins          = pins_of(state);
    assign bus.cam_pwdn  = pins.pwdn;
    assign bus.cam_rst_n = pins.rst_n;
    assign bus.xclk_en   = pins.xclk_en;
    assign bus.busy      = pins.busy;
    assign bus.ready     = pins.ready;
    assign bus.tick_us   = tick;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Self-checking bench for cam_pwr_seq: directed timing scenarios plus randomized start/abort/reset.
module tb_cam_pwr_seq;

    localparam int unsigned DIV = 4;
    localparam int unsigned TP  = 3;
    localparam int unsigned TR  = 2;
    localparam int unsigned TS  = 5;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    cam_pwr_seq_if bus ();

    cam_pwr_seq #(
        .TICK_DIV   (DIV),
        .T_PWDN_US  (TP),
        .T_RST_US   (TR),
        .T_SETTLE_US(TS),
        .CNT_W      (16)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk    = 0;
    int n_err    = 0;
    int tick_cnt = 0;
    int rel      = 0;

    // Model: phase 0 idle, 1..3 timed phases, 4 ready; m_el counts cycles spent in the phase.
    int m_ph = 0;
    int m_el = 0;

    function automatic int dur(input int ph);
        case (ph)
            1:       return TP * DIV;
            2:       return TR * DIV;
            3:       return TS * DIV;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] model_out();
        logic timed;
        timed = (m_ph >= 1) && (m_ph <= 3);
        return {m_ph <= 1, m_ph >= 3, m_ph >= 2, timed, m_ph == 4,
                timed && ((m_el % DIV) == DIV - 1)};
    endfunction

    function automatic logic [4:0] pins5();
        return {bus.cam_pwdn, bus.cam_rst_n, bus.xclk_en, bus.busy, bus.ready};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            if (!reset) begin
                m_ph = 0;
                m_el = 0;
            end
            chk("model", {pins5(), bus.tick_us}, model_out());
            if (bus.tick_us) tick_cnt++;
            if (reset) begin
                if (bus.abort && m_ph != 0) begin
                    m_ph = 0;
                    m_el = 0;
                end else if (bus.start && (m_ph == 0 || m_ph == 4)) begin
                    m_ph = 1;
                    m_el = 0;
                end else if (m_ph >= 1 && m_ph <= 3) begin
                    if (m_el == dur(m_ph) - 1) begin
                        m_ph++;
                        m_el = 0;
                    end else begin
                        m_el++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
        rel++;
    endtask

    task automatic go_to(input int t);
        while (rel < t) step();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic begin_seq();
        rel = 0;
        pulse_start();
    endtask

    int t0;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (6) step();
        chk("idle_pins", pins5(), 5'b10000);
        chk("idle_no_tick", tick_cnt, 0);

        // Full sequence from IDLE
        t0 = tick_cnt;
        begin_seq();
        chk("busy@1", bus.busy, 1);
        chk("pwdn@1", bus.cam_pwdn, 1);
        go_to(3);  chk("tick@3", bus.tick_us, 0);
        go_to(4);  chk("tick@4", bus.tick_us, 1);
        go_to(12); chk("pwdn@12", bus.cam_pwdn, 1);
        go_to(13); chk("pwdn@13", bus.cam_pwdn, 0);
        chk("xclk@13", bus.xclk_en, 1);
        go_to(20); chk("rstn@20", bus.cam_rst_n, 0);
        go_to(21); chk("rstn@21", bus.cam_rst_n, 1);
        go_to(40); chk("ready@40", {bus.ready, bus.busy}, 2'b01);
        go_to(41); chk("ready@41", {bus.ready, bus.busy}, 2'b10);
        chk("tick_count", tick_cnt - t0, 10);

        // Restart from READY with starts ignored while busy
        begin_seq();
        go_to(5);  pulse_start();
        go_to(12); chk("ign_pwdn@12", bus.cam_pwdn, 1);
        go_to(13); chk("ign_pwdn@13", bus.cam_pwdn, 0);
        go_to(20); chk("ign_rstn@20", bus.cam_rst_n, 0);
        go_to(21); chk("ign_rstn@21", bus.cam_rst_n, 1);
        go_to(30); pulse_start();
        go_to(40); chk("ign_ready@40", bus.ready, 0);
        go_to(41); chk("ign_ready@41", bus.ready, 1);

        // Abort during RST_REL, then a fresh start
        begin_seq();
        go_to(25);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_pins@26", pins5(), 5'b10000);
        go_to(30); pulse_start();
        go_to(70); chk("abort_ready@70", bus.ready, 0);
        go_to(71); chk("abort_ready@71", bus.ready, 1);

        // start and abort together in READY: abort wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("both_pins", pins5(), 5'b10000);
        repeat (5) step();
        chk("both_stay_idle", pins5(), 5'b10000);

        // Asynchronous reset in CLK_ON
        begin_seq();
        go_to(18);
        chk("clkon@18", pins5(), 5'b00110);
        reset = 1'b0;
        #1;
        chk("async_rst_pins", pins5(), 5'b10000);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        chk("post_rst_idle", pins5(), 5'b10000);
        begin_seq();
        while (!bus.ready && rel < 100) step();
        chk("post_rst_latency", rel, 41);

        // Randomized start/abort/reset traffic
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 19) == 0);
            bus.abort = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
